// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM encodings and fixed field values.
// No logic, so no latency or backpressure of its own.
package rv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam int          RUN_CNT_W = 4;
    localparam logic [3:0]  FETCH_SEL = 4'hF;

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Bundles the fetch port, exec data port and memory port seen by the arbiter.
// Wiring only; slave = arbiter side, master = core/memory side.
interface rv_mem_arbiter_if;

    logic [31:0] im_addr_i;
    logic        im_rd_i;
    logic        im_ready_o;
    logic [31:0] im_data_o;
    logic        im_valid_o;

    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  im_addr_i, im_rd_i,
        output im_ready_o, im_data_o, im_valid_o,
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
        output dm_ready_o, dm_data_l_o, dm_load_done_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
        input  mem_ack_i, mem_data_i
    );

    modport master (
        output im_addr_i, im_rd_i,
        input  im_ready_o, im_data_o, im_valid_o,
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
        input  dm_ready_o, dm_data_l_o, dm_load_done_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o,
        output mem_ack_i, mem_data_i
    );

endinterface

// File: rtl/rv_arb_fairness.sv
// Counts data grants made while a fetch waits; forces a fetch grant once the run limit is hit.
// force_fetch is combinational from the registered count; no backpressure.
module rv_arb_fairness
    import rv_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic grant_d,
    input  logic grant_i,
    input  logic im_rd_i,
    output logic force_fetch
);

    localparam logic [RUN_CNT_W-1:0] MAX_CNT = RUN_CNT_W'(MAX_DATA_RUN);

    logic [RUN_CNT_W-1:0] run_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_cnt <= '0;
        end else if (grant_d) begin
            if (!im_rd_i)
                run_cnt <= '0;
            else if (run_cnt != MAX_CNT)
                run_cnt <= run_cnt + 1'b1;
        end else if (grant_i) begin
            run_cnt <= '0;
        end
    end

    assign force_fetch = im_rd_i && (run_cnt == MAX_CNT);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-ported memory between fetch and exec data; data wins unless fetch is starved.
// Accept->mem_req next cycle, done pulse the cycle after ack; one transaction in flight, ready low while busy.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    rv_mem_arbiter_if.slave   bus
);

    arb_state_e  state_q, state_d;
    logic        data_req, grant_d, grant_i, force_fetch;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] im_data_q, dm_data_q;
    logic        im_valid_q, dm_done_q;

    rv_arb_fairness #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_fairness (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .grant_d     (grant_d),
        .grant_i     (grant_i),
        .im_rd_i     (bus.im_rd_i),
        .force_fetch (force_fetch)
    );

    // Grants are qualified by reset so both readies read 0 while reset is held.
    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        data_req = bus.dm_load_i | bus.dm_store_i;
        case (state_q)
            ARB_IDLE: begin
                if (rst_n_i) begin
                    if (data_req && !force_fetch) begin
                        grant_d = 1'b1;
                        state_d = ARB_BUSY_D;
                    end else if (bus.im_rd_i) begin
                        grant_i = 1'b1;
                        state_d = ARB_BUSY_I;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (bus.mem_ack_i)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    // A combined load+store request is issued as a single write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else if (grant_d) begin
            we_q    <= bus.dm_store_i;
            addr_q  <= bus.dm_addr_i;
            wdata_q <= bus.dm_data_s_i;
            sel_q   <= bus.dm_data_select_i;
        end else if (grant_i) begin
            we_q    <= 1'b0;
            addr_q  <= bus.im_addr_i;
            sel_q   <= FETCH_SEL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            im_data_q  <= '0;
            dm_data_q  <= '0;
            im_valid_q <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            im_valid_q <= (state_q == ARB_BUSY_I) && bus.mem_ack_i;
            dm_done_q  <= (state_q == ARB_BUSY_D) && bus.mem_ack_i && !we_q;
            if ((state_q == ARB_BUSY_I) && bus.mem_ack_i)
                im_data_q <= bus.mem_data_i;
            if ((state_q == ARB_BUSY_D) && bus.mem_ack_i && !we_q)
                dm_data_q <= bus.mem_data_i;
        end
    end

    assign bus.im_ready_o     = grant_i;
    assign bus.dm_ready_o     = grant_d;
    assign bus.im_data_o      = im_data_q;
    assign bus.im_valid_o     = im_valid_q;
    assign bus.dm_data_l_o    = dm_data_q;
    assign bus.dm_load_done_o = dm_done_q;
    assign bus.mem_req_o      = (state_q != ARB_IDLE);
    assign bus.mem_we_o       = we_q;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_data_o     = wdata_q;
    assign bus.mem_sel_o      = sel_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: memory responder with programmable ack delay plus a read-data scoreboard.
module tb_rv_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rv_mem_arbiter_if bus();

    rv_mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit resp_en = 1'b1;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] mon_e;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acks after ack_delay extra request cycles, returns mem_model(addr).
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                bus.mem_ack_i = 1'b0;
                if (bus.mem_req_o) begin
                    if (wait_cnt >= ack_delay) begin
                        bus.mem_ack_i  = 1'b1;
                        bus.mem_data_i = mem_model(bus.mem_addr_o);
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Scoreboard: pop on completion pulses first, then push for the grant at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.im_valid_o) begin
                checks++;
                if (exp_i.size() == 0) begin
                    $display("FAIL im_valid_pulse: unexpected pulse, im_data_o=%h", bus.im_data_o);
                end else begin
                    mon_e = exp_i.pop_front();
                    if (bus.im_data_o !== mon_e)
                        $display("FAIL im_data: got %h expected %h", bus.im_data_o, mon_e);
                    else
                        passes++;
                end
            end
            if (bus.dm_load_done_o) begin
                checks++;
                if (exp_d.size() == 0) begin
                    $display("FAIL dm_done_pulse: unexpected pulse, dm_data_l_o=%h", bus.dm_data_l_o);
                end else begin
                    mon_e = exp_d.pop_front();
                    if (bus.dm_data_l_o !== mon_e)
                        $display("FAIL dm_data_l: got %h expected %h", bus.dm_data_l_o, mon_e);
                    else
                        passes++;
                end
            end
            if (bus.im_ready_o)
                exp_i.push_back(mem_model(bus.im_addr_i));
            if (bus.dm_ready_o && bus.dm_load_i && !bus.dm_store_i)
                exp_d.push_back(mem_model(bus.dm_addr_i));
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        bus.im_rd_i = 1'b1;
        bus.dm_load_i = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o,
             bus.im_data_o, bus.dm_data_l_o, bus.im_valid_o, bus.dm_load_done_o} !== '0)
            $display("FAIL reset_outputs: req=%b we=%b addr=%h data=%h sel=%h imd=%h dmd=%h v=%b d=%b expected all 0",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o,
                     bus.im_data_o, bus.dm_data_l_o, bus.im_valid_o, bus.dm_load_done_o);
        else
            passes++;
        checks++;
        if ({bus.im_ready_o, bus.dm_ready_o} !== 2'b00)
            $display("FAIL reset_ready: got %b expected 00", {bus.im_ready_o, bus.dm_ready_o});
        else
            passes++;
        repeat (2) @(posedge clk);
        #1;
        bus.im_rd_i = 1'b0;
        bus.dm_load_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_lone_fetch;
        ack_delay = 0;
        @(posedge clk); #1;
        bus.im_addr_i = 32'h100;
        bus.im_rd_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.im_ready_o, bus.dm_ready_o} !== 2'b10)
            $display("FAIL fetch_ready: im/dm ready=%b expected 10", {bus.im_ready_o, bus.dm_ready_o});
        else
            passes++;
        @(posedge clk); #1;
        bus.im_rd_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o} !== {1'b1, 1'b0, 32'h100, 4'hF})
            $display("FAIL fetch_req: req=%b we=%b addr=%h sel=%h expected 1 0 00000100 f",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o);
        else
            passes++;
        @(negedge clk);
        checks++;
        if (bus.im_valid_o !== 1'b1 || bus.im_data_o !== mem_model(32'h100) || bus.mem_req_o !== 1'b0)
            $display("FAIL fetch_done: valid=%b data=%h req=%b expected 1 %h 0",
                     bus.im_valid_o, bus.im_data_o, bus.mem_req_o, mem_model(32'h100));
        else
            passes++;
    endtask

    task automatic test_store_vs_fetch;
        int d = 0;
        @(posedge clk); #1;
        bus.im_addr_i = 32'h180;
        bus.im_rd_i = 1'b1;
        bus.dm_addr_i = 32'h2000;
        bus.dm_data_s_i = 32'hDEADBEEF;
        bus.dm_data_select_i = 4'b0011;
        bus.dm_store_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.im_ready_o, bus.dm_ready_o} !== 2'b01)
            $display("FAIL store_priority: im/dm ready=%b expected 01", {bus.im_ready_o, bus.dm_ready_o});
        else
            passes++;
        @(posedge clk); #1;
        bus.dm_store_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o, bus.im_ready_o}
            !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1'b0})
            $display("FAIL store_req: req=%b we=%b addr=%h data=%h sel=%b imrdy=%b expected 1 1 00002000 deadbeef 0011 0",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o, bus.im_ready_o);
        else
            passes++;
        @(negedge clk);
        if (bus.dm_load_done_o) d++;
        checks++;
        if (bus.im_ready_o !== 1'b1)
            $display("FAIL fetch_after_store: im_ready=%b expected 1", bus.im_ready_o);
        else
            passes++;
        @(posedge clk); #1;
        bus.im_rd_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dm_load_done_o) d++;
        end
        checks++;
        if (d != 0)
            $display("FAIL store_no_done: done pulses=%0d expected 0", d);
        else
            passes++;
    endtask

    task automatic test_fairness;
        int n = 0;
        ack_delay = 0;
        @(posedge clk); #1;
        bus.im_addr_i = 32'h300;
        bus.dm_addr_i = 32'h400;
        bus.dm_data_select_i = 4'hF;
        bus.dm_load_i = 1'b1;
        bus.im_rd_i = 1'b1;
        for (int k = 0; k < 80 && n < 15; k++) begin
            @(negedge clk);
            if (bus.dm_ready_o || bus.im_ready_o) begin
                checks++;
                if (bus.dm_ready_o !== (n % 5 != 4) || bus.im_ready_o !== (n % 5 == 4))
                    $display("FAIL fair_grant_%0d: dm/im ready=%b%b expected %b%b", n,
                             bus.dm_ready_o, bus.im_ready_o, (n % 5 != 4), (n % 5 == 4));
                else
                    passes++;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.dm_load_i = 1'b0;
        bus.im_rd_i = 1'b0;
        checks++;
        if (n != 15)
            $display("FAIL fair_count: grants=%0d expected 15", n);
        else
            passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_delay;
        int d = 0;
        ack_delay = 5;
        @(posedge clk); #1;
        bus.dm_addr_i = 32'h500;
        bus.dm_data_select_i = 4'hC;
        bus.dm_load_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.dm_ready_o !== 1'b1)
            $display("FAIL delay_ready: dm_ready=%b expected 1", bus.dm_ready_o);
        else
            passes++;
        @(posedge clk); #1;
        bus.dm_load_i = 1'b0;
        bus.im_addr_i = 32'h580;
        bus.im_rd_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.im_ready_o, bus.dm_ready_o}
                !== {1'b1, 1'b0, 32'h500, 4'hC, 1'b0, 1'b0})
                $display("FAIL stall_%0d: req=%b we=%b addr=%h sel=%h rdy=%b%b expected 1 0 00000500 c 00", k,
                         bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.im_ready_o, bus.dm_ready_o);
            else
                passes++;
        end
        @(negedge clk);
        ack_delay = 0;
        @(negedge clk);
        if (bus.dm_load_done_o) d++;
        checks++;
        if (bus.dm_load_done_o !== 1'b1 || bus.im_ready_o !== 1'b1)
            $display("FAIL delay_done: done=%b im_ready=%b expected 1 1", bus.dm_load_done_o, bus.im_ready_o);
        else
            passes++;
        @(posedge clk); #1;
        bus.im_rd_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.dm_load_done_o) d++;
        end
        checks++;
        if (d != 1)
            $display("FAIL delay_one_pulse: pulses=%0d expected 1", d);
        else
            passes++;
    endtask

    task automatic test_reset_busy;
        int d = 0;
        ack_delay = 20;
        @(posedge clk); #1;
        bus.dm_addr_i = 32'h600;
        bus.dm_load_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.dm_load_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b1)
            $display("FAIL busy_before_reset: req=%b expected 1", bus.mem_req_o);
        else
            passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b0)
            $display("FAIL async_reset_req: req=%b expected 0", bus.mem_req_o);
        else
            passes++;
        exp_d.delete();
        ack_delay = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.dm_load_done_o) d++;
        end
        checks++;
        if (d != 0 || bus.mem_req_o !== 1'b0)
            $display("FAIL reset_abandon: pulses=%0d req=%b expected 0 0", d, bus.mem_req_o);
        else
            passes++;
        @(posedge clk); #1;
        bus.im_addr_i = 32'h700;
        bus.im_rd_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.im_ready_o !== 1'b1)
            $display("FAIL idle_after_reset: im_ready=%b expected 1", bus.im_ready_o);
        else
            passes++;
        @(posedge clk); #1;
        bus.im_rd_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_idle;
        logic [63:0] hold;
        repeat (2) @(negedge clk);
        resp_en = 1'b0;
        hold = {bus.im_data_o, bus.dm_data_l_o};
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b1;
        bus.mem_data_i = 32'hFFFF_0000;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_o, bus.im_valid_o, bus.dm_load_done_o} !== 3'b000 ||
            {bus.im_data_o, bus.dm_data_l_o} !== hold)
            $display("FAIL idle_ack: req/v/d=%b%b%b data=%h expected 000 %h",
                     bus.mem_req_o, bus.im_valid_o, bus.dm_load_done_o, {bus.im_data_o, bus.dm_data_l_o}, hold);
        else
            passes++;
        resp_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int last = 0;
        bit ok;
        ack_delay = 0;
        bus.dm_data_select_i = 4'hF;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            bus.dm_addr_i = $urandom & 32'hFFFF_FFFC;
            bus.dm_load_i = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.dm_ready_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok || (t > 0 && cyc - last != 2))
                $display("FAIL b2b_accept_%0d: accepted=%b gap=%0d expected 1 2", t, ok, cyc - last);
            else
                passes++;
            last = cyc;
        end
        @(posedge clk); #1;
        bus.dm_load_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, checks);
        $fatal(1);
    end

    initial begin
        bus.im_addr_i = '0;
        bus.im_rd_i = 1'b0;
        bus.dm_addr_i = '0;
        bus.dm_data_s_i = '0;
        bus.dm_data_select_i = '0;
        bus.dm_load_i = 1'b0;
        bus.dm_store_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        bus.mem_data_i = '0;
        test_reset();
        test_lone_fetch();
        test_store_vs_fetch();
        test_fairness();
        test_ack_delay();
        test_reset_busy();
        test_ack_idle();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0)
            $display("FAIL scoreboard_drain: pending fetch=%0d load=%0d expected 0 0", exp_i.size(), exp_d.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
